cory_gather: RTL and testbench

//  Join counterpart of the vr distributor: collects one word from each of N

---
 rtl/cory_gather_pkg.sv | 13 +
 rtl/cory_gather_lane.sv | 48 ++++
 rtl/cory_gather.sv | 70 +++++++
 tb/tb_cory_gather.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cory_gather_pkg.sv
// Shared definitions for the cory_gather join: default geometry and the
// lane-slice helper used to locate lane k inside a packed N*W word.
package cory_gather_pkg;

  localparam int unsigned CoryDefaultN = 8;
  localparam int unsigned CoryDefaultW = 8;

  // LSB position of a lane inside a concatenated word ([lane*width +: width]).
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/cory_gather_lane.sv
// One gather lane: a capture flag plus a W-bit data register. The lane
// accepts exactly one word per set and refuses more until cleared.
module cory_gather_lane
  import cory_gather_pkg::*;
#(
  parameter int unsigned W = CoryDefaultW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_v,
  input  logic [W-1:0] i_d,
  output logic         o_r,
  input  logic         i_clr,
  output logic         o_hold,
  output logic [W-1:0] o_d
);

  logic         hold_q, hold_d;
  logic [W-1:0] data_q, data_d;

  // Clear wins over capture; a captured word is kept until the set drains.
  always_comb begin
    hold_d = hold_q;
    data_d = data_q;
    if (i_clr) begin
      hold_d = 1'b0;
    end else if (i_v && !hold_q) begin
      hold_d = 1'b1;
      data_d = i_d;
    end
  end

  // Lane state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
      data_q <= '0;
    end else begin
      hold_q <= hold_d;
      data_q <= data_d;
    end
  end

  assign o_r    = !hold_q;
  assign o_hold = hold_q;
  assign o_d    = data_q;

endmodule

// File: rtl/cory_gather.sv
// cory_gather: joins N independent valid/ready lanes into one concatenated
// word. Each lane is captured once per set; the set is released downstream
// once every lane has arrived.
// Build option CORY_GATHER_PASS_EN: lanes arriving in the completing cycle
// pass straight through to o_z_d, giving a zero-latency set path.
module cory_gather
  import cory_gather_pkg::*;
#(
  parameter int unsigned N = CoryDefaultN,
  parameter int unsigned W = CoryDefaultW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   i_ax_v,
  input  logic [N*W-1:0] i_ax_d,
  output logic [N-1:0]   o_ax_r,
  output logic           o_z_v,
  output logic [N*W-1:0] o_z_d,
  input  logic           i_z_r,
  output logic [N-1:0]   o_held
);

  logic [N-1:0]   hold;
  logic [N*W-1:0] data;
  logic           clr;

  // Downstream handshake releases every lane at once.
  assign clr = o_z_v & i_z_r;

  for (genvar k = 0; k < N; k++) begin : g_lane
    cory_gather_lane #(
      .W(W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .i_v   (i_ax_v[k]),
      .i_d   (i_ax_d[lane_lsb(k, W) +: W]),
      .o_r   (o_ax_r[k]),
      .i_clr (clr),
      .o_hold(hold[k]),
      .o_d   (data[lane_lsb(k, W) +: W])
    );
  end

  assign o_held = hold;

`ifdef CORY_GATHER_PASS_EN
  logic [N-1:0] arrive;

  // A lane counts as present if held or handshaking this cycle; data of
  // not-yet-held lanes is forwarded from the input.
  always_comb begin
    arrive = hold | (i_ax_v & o_ax_r);
    o_z_d  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      o_z_d[lane_lsb(k, W) +: W] = hold[k] ? data[lane_lsb(k, W) +: W]
                                           : i_ax_d[lane_lsb(k, W) +: W];
    end
  end

  assign o_z_v = &arrive;
`else
  // Registered output: the set is valid only once all lanes are held.
  always_comb begin
    o_z_v = &hold;
    o_z_d = data;
  end
`endif

endmodule

// File: tb/tb_cory_gather.sv
// Self-checking bench for cory_gather (N=4, W=8). A set-level reference model
// (per-lane captured flags and words) predicts ready, held, z_v and z_d every
// cycle; directed scenarios add fixed expectations on top of random traffic.
module tb_cory_gather;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   i_ax_v;
  logic [N*W-1:0] i_ax_d;
  logic [N-1:0]   o_ax_r;
  logic           o_z_v;
  logic [N*W-1:0] o_z_d;
  logic           i_z_r;
  logic [N-1:0]   o_held;

  always #5 clk = ~clk;

  cory_gather #(
    .N(N),
    .W(W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .i_ax_v(i_ax_v),
    .i_ax_d(i_ax_d),
    .o_ax_r(o_ax_r),
    .o_z_v (o_z_v),
    .o_z_d (o_z_d),
    .i_z_r (i_z_r),
    .o_held(o_held)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_sets   = 0;

  // Reference model: which lanes already delivered a word to the current set.
  logic [N-1:0] m_hold;
  logic [W-1:0] m_data[N];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Set is complete when every lane has contributed (held, or arriving now
  // in pass-through builds).
  function automatic logic model_zv(input logic [N-1:0] v);
`ifdef CORY_GATHER_PASS_EN
    return &(m_hold | v);
`else
    return &m_hold;
`endif
  endfunction

  function automatic logic [N*W-1:0] model_zd(input logic [N*W-1:0] d);
    logic [N*W-1:0] z;
    for (int k = 0; k < N; k++) begin
`ifdef CORY_GATHER_PASS_EN
      z[k*W +: W] = m_hold[k] ? m_data[k] : d[k*W +: W];
`else
      z[k*W +: W] = m_data[k];
`endif
    end
    return z;
  endfunction

  // One clock: drive, compare against model mid-cycle, clock, advance model.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic zr,
                      input logic rst);
    logic [N-1:0] exp_r;
    logic         zv;
    i_ax_v = v;
    i_ax_d = d;
    i_z_r  = zr;
    reset  = rst;
    #2;
    exp_r = ~m_hold;
    zv    = model_zv(v);
    check_eq("ready", o_ax_r, exp_r);
    check_eq("held", o_held, m_hold);
    check_eq("z_v", o_z_v, zv);
    if (zv) check_eq("z_d", o_z_d, model_zd(d));
    if (o_z_v && zr) n_sets++;
    @(posedge clk);
    if (rst) begin
      m_hold = '0;
      for (int k = 0; k < N; k++) m_data[k] = '0;
    end else if (zv && zr) begin
      m_hold = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (v[k] && !m_hold[k]) begin
          m_hold[k] = 1'b1;
          m_data[k] = d[k*W +: W];
        end
      end
    end
    #1;
  endtask

  logic [N*W-1:0] saved_zd;
  logic [N-1:0]   held_tbl[10];
  logic [N-1:0]   v_tbl[10];
  logic [31:0]    rnd;

  initial begin
    // Reset and post-reset state.
    i_ax_v = '0;
    i_ax_d = '0;
    i_z_r  = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    m_hold = '0;
    for (int k = 0; k < N; k++) m_data[k] = '0;
    check_eq("rst_held", o_held, 4'h0);
    check_eq("rst_ready", o_ax_r, 4'hF);
    check_eq("rst_zv", o_z_v, 1'b0);
    check_eq("rst_zd", o_z_d, 32'h0);

    // 1: all lanes together.
    step(4'hF, 32'h13121110, 1'b1, 1'b0);
`ifndef CORY_GATHER_PASS_EN
    check_eq("t1_zv", o_z_v, 1'b1);
    check_eq("t1_zd", o_z_d, 32'h13121110);
    step(4'h0, 32'h0, 1'b1, 1'b0);
`endif
    check_eq("t1_drained", o_held, 4'h0);

    // 2: staggered arrival 2,0,3,1 on cycles 0,3,4,9.
    v_tbl    = '{4'h4, 4'h0, 4'h0, 4'h1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
    held_tbl = '{4'h4, 4'h4, 4'h4, 4'h5, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF};
    for (int c = 0; c < 10; c++) begin
      step(v_tbl[c], 32'hA3A2A1A0, 1'b0, 1'b0);
      check_eq("t2_held", o_held, held_tbl[c]);
      check_eq("t2_zv", o_z_v, c == 9);
    end
    check_eq("t2_zd", o_z_d, 32'hA3A2A1A0);

    // 3: downstream stalls; lane 0 re-presents 0xAA.
    saved_zd = o_z_d;
    for (int c = 0; c < 5; c++) begin
      step(4'h1, 32'h000000AA, 1'b0, 1'b0);
      check_eq("t3_zv", o_z_v, 1'b1);
      check_eq("t3_zd", o_z_d, saved_zd);
      check_eq("t3_ready", o_ax_r, 4'h0);
    end
    step(4'h1, 32'h000000AA, 1'b1, 1'b0);
    check_eq("t3_drain_held", o_held, 4'h0);
    step(4'h1, 32'h000000AA, 1'b0, 1'b0);
    check_eq("t3_recapture", o_held, 4'h1);

    // 4: reset after lanes 0,1 captured; then a fresh set.
    step(4'h2, 32'h0000BB00, 1'b0, 1'b0);
    check_eq("t4_partial", o_held, 4'h3);
    step(4'h0, 32'h0, 1'b0, 1'b1);
    check_eq("t4_held", o_held, 4'h0);
    check_eq("t4_zv", o_z_v, 1'b0);
    check_eq("t4_ready", o_ax_r, 4'hF);
    step(4'hF, 32'h44332211, 1'b0, 1'b0);
    check_eq("t4_zv_new", o_z_v, 1'b1);
    check_eq("t4_zd_new", o_z_d, 32'h44332211);
    step(4'h0, 32'h0, 1'b1, 1'b0);

    // 5: back-to-back sets with everything always ready.
    n_sets = 0;
    for (int c = 0; c < 8; c++) begin
      rnd = $urandom;
      step(4'hF, rnd, 1'b1, 1'b0);
    end
`ifdef CORY_GATHER_PASS_EN
    check_eq("t5_rate", n_sets, 8);
`else
    check_eq("t5_rate", n_sets, 4);
`endif

    // 6: random valid/ready with rare resets.
    for (int c = 0; c < 4000; c++) begin
      rnd = $urandom;
      step(4'($urandom), rnd, $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
